// File: rtl/adder_arbiter.sv
// adder_arbiter
//   Round-robin arbiter that lends one shared 4-bit ripple-carry adder to two
//   requesters. A single operation runs at a time:
//     IDLE   -> pick a winner, register its operands onto the adder inputs
//     SETTLE -> hold the adder inputs for SETTLE_CYCLES cycles, then capture
//     DONE   -> pulse done for the winner, hand priority to the other side
//
//   Handshake: req0/req1 are level requests and are only looked at in IDLE.
//   gnt<n> pulses for the first SETTLE cycle. That is the cycle after the
//   request was sampled, and at that point the operands are already latched.
//   done<n> pulses for the single DONE cycle, and result is valid from then
//   until the next capture. A requester keeping req high is served again only
//   after the block has returned to IDLE.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   req0/req1           level requests
//   a0,b0,cin0 / a1,b1,cin1   operands of requester 0 / 1
//   gnt0/gnt1           one-cycle grant pulses
//   done0/done1         one-cycle completion pulses
//   result              captured {carry, sum[3:0]}
//   busy                high whenever the FSM is not in IDLE
//   add_a/add_b/add_cin registered drive to the shared adder
//   add_sum             combinational sum returned by the shared adder
//   fsm_state           current FSM state (debug observation only)
module adder_arbiter #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0,
    input  logic       req1,
    input  logic [3:0] a0,
    input  logic [3:0] b0,
    input  logic       cin0,
    input  logic [3:0] a1,
    input  logic [3:0] b1,
    input  logic       cin1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       done0,
    output logic       done1,
    output logic [4:0] result,
    output logic       busy,
    output logic [3:0] add_a,
    output logic [3:0] add_b,
    output logic       add_cin,
    input  logic [4:0] add_sum,
    output logic [1:0] fsm_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] cnt;
    logic       ptr;     // requester holding priority when both ask
    logic       owner;   // requester being served by the current operation
    logic       start;
    logic       win;

    // A lone requester wins outright; the pointer only breaks ties.
    always_comb begin
        win   = (req0 && req1) ? ptr : req1;
        start = (state == IDLE) && (req0 || req1);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SETTLE;
            SETTLE:  if (cnt == 4'd1) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= 4'd0;
            ptr     <= 1'b0;
            owner   <= 1'b0;
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            result  <= 5'd0;
            add_a   <= 4'd0;
            add_b   <= 4'd0;
            add_cin <= 1'b0;
        end else begin
            // Grants are single-cycle pulses; they default low every edge.
            gnt0 <= 1'b0;
            gnt1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        owner   <= win;
                        add_a   <= win ? a1 : a0;
                        add_b   <= win ? b1 : b0;
                        add_cin <= win ? cin1 : cin0;
                        cnt     <= SETTLE_LOAD;
                        gnt0    <= ~win;
                        gnt1    <= win;
                    end
                end
                SETTLE: begin
                    cnt <= cnt - 4'd1;
                    // The adder inputs have been stable for SETTLE_CYCLES
                    // cycles by the time the counter reaches 1.
                    if (cnt == 4'd1) begin
                        result <= add_sum;
                    end
                end
                DONE: begin
                    ptr <= ~owner;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        done0     = (state == DONE) && !owner;
        done1     = (state == DONE) && owner;
        busy      = (state != IDLE);
        fsm_state = state;
    end

endmodule

// File: tb/tb_adder_arbiter.sv
// Bench for adder_arbiter. Three instances (SETTLE_CYCLES = 2, 1, 15) share
// the same stimulus. Each instance has its own shared-adder model. A
// transaction-level reference predicts every output cycle by cycle. It keeps
// an in-flight operation, with its start edge and its winner, and derives the
// timing of gnt, done and busy from arithmetic on edge numbers. Instance 0
// also keeps an expected-result queue that is checked on every done pulse.
module tb_adder_arbiter;

    localparam int N_INST = 3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       req0, req1, cin0, cin1;
    logic [3:0] a0, b0, a1, b1;

    logic       gnt0_v    [N_INST];
    logic       gnt1_v    [N_INST];
    logic       done0_v   [N_INST];
    logic       done1_v   [N_INST];
    logic       busy_v    [N_INST];
    logic       add_cin_v [N_INST];
    logic [4:0] result_v  [N_INST];
    logic [4:0] add_sum_v [N_INST];
    logic [3:0] add_a_v   [N_INST];
    logic [3:0] add_b_v   [N_INST];
    logic [1:0] state_v   [N_INST];

    adder_arbiter #(.SETTLE_CYCLES(2)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1),
        .a0(a0), .b0(b0), .cin0(cin0), .a1(a1), .b1(b1), .cin1(cin1),
        .gnt0(gnt0_v[0]), .gnt1(gnt1_v[0]), .done0(done0_v[0]), .done1(done1_v[0]),
        .result(result_v[0]), .busy(busy_v[0]), .add_a(add_a_v[0]), .add_b(add_b_v[0]),
        .add_cin(add_cin_v[0]), .add_sum(add_sum_v[0]), .fsm_state(state_v[0]));

    adder_arbiter #(.SETTLE_CYCLES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1),
        .a0(a0), .b0(b0), .cin0(cin0), .a1(a1), .b1(b1), .cin1(cin1),
        .gnt0(gnt0_v[1]), .gnt1(gnt1_v[1]), .done0(done0_v[1]), .done1(done1_v[1]),
        .result(result_v[1]), .busy(busy_v[1]), .add_a(add_a_v[1]), .add_b(add_b_v[1]),
        .add_cin(add_cin_v[1]), .add_sum(add_sum_v[1]), .fsm_state(state_v[1]));

    adder_arbiter #(.SETTLE_CYCLES(15)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1),
        .a0(a0), .b0(b0), .cin0(cin0), .a1(a1), .b1(b1), .cin1(cin1),
        .gnt0(gnt0_v[2]), .gnt1(gnt1_v[2]), .done0(done0_v[2]), .done1(done1_v[2]),
        .result(result_v[2]), .busy(busy_v[2]), .add_a(add_a_v[2]), .add_b(add_b_v[2]),
        .add_cin(add_cin_v[2]), .add_sum(add_sum_v[2]), .fsm_state(state_v[2]));

    // Shared ripple-carry adders, one per instance.
    assign add_sum_v[0] = {1'b0, add_a_v[0]} + {1'b0, add_b_v[0]} + {4'd0, add_cin_v[0]};
    assign add_sum_v[1] = {1'b0, add_a_v[1]} + {1'b0, add_b_v[1]} + {4'd0, add_cin_v[1]};
    assign add_sum_v[2] = {1'b0, add_a_v[2]} + {1'b0, add_b_v[2]} + {4'd0, add_cin_v[2]};

    // ---------------- reference model ----------------
    int         k;                   // number of rising edges seen so far
    bit         m_active [N_INST];
    int         m_start  [N_INST];   // edge at which the request was accepted
    bit         m_win    [N_INST];
    bit         m_ptr    [N_INST];
    logic [3:0] m_a      [N_INST];
    logic [3:0] m_b      [N_INST];
    logic       m_cin    [N_INST];
    logic [4:0] m_res    [N_INST];
    logic [4:0] exp_q[$];            // expected results of instance 0, in order

    int n_checks = 0;
    int n_errors = 0;

    function automatic int settle_of(input int i);
        case (i)
            0:       return 2;
            1:       return 1;
            default: return 15;
        endcase
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h (edge %0d)", tag, got, exp, k);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N_INST; i++) begin
            m_active[i] = 1'b0;
            m_start[i]  = 0;
            m_win[i]    = 1'b0;
            m_ptr[i]    = 1'b0;
            m_a[i]      = 4'd0;
            m_b[i]      = 4'd0;
            m_cin[i]    = 1'b0;
            m_res[i]    = 5'd0;
        end
        exp_q.delete();
    endtask

    // Called right after a rising edge. Inputs are stable because they were
    // driven at the preceding falling edge.
    task automatic model_edge();
        int s;
        k++;
        if (!rst_n) begin
            model_reset();
            return;
        end
        for (int i = 0; i < N_INST; i++) begin
            s = settle_of(i);
            if (m_active[i]) begin
                if (k == m_start[i] + s) begin
                    m_res[i] = {1'b0, m_a[i]} + {1'b0, m_b[i]} + {4'd0, m_cin[i]};
                end else if (k == m_start[i] + s + 1) begin
                    m_active[i] = 1'b0;
                    m_ptr[i]    = ~m_win[i];
                end
            end else if (req0 || req1) begin
                m_win[i]    = (req0 && req1) ? m_ptr[i] : req1;
                m_a[i]      = m_win[i] ? a1 : a0;
                m_b[i]      = m_win[i] ? b1 : b0;
                m_cin[i]    = m_win[i] ? cin1 : cin0;
                m_active[i] = 1'b1;
                m_start[i]  = k;
                if (i == 0) exp_q.push_back({1'b0, m_a[i]} + {1'b0, m_b[i]} + {4'd0, m_cin[i]});
            end
        end
    endtask

    task automatic check_outputs();
        bit g, d;
        for (int i = 0; i < N_INST; i++) begin
            g = m_active[i] && (k == m_start[i]);
            d = m_active[i] && (k == m_start[i] + settle_of(i));
            check_val($sformatf("gnt0[%0d]", i),    gnt0_v[i],    g && !m_win[i]);
            check_val($sformatf("gnt1[%0d]", i),    gnt1_v[i],    g && m_win[i]);
            check_val($sformatf("done0[%0d]", i),   done0_v[i],   d && !m_win[i]);
            check_val($sformatf("done1[%0d]", i),   done1_v[i],   d && m_win[i]);
            check_val($sformatf("busy[%0d]", i),    busy_v[i],    m_active[i]);
            check_val($sformatf("result[%0d]", i),  result_v[i],  m_res[i]);
            check_val($sformatf("add_a[%0d]", i),   add_a_v[i],   m_a[i]);
            check_val($sformatf("add_b[%0d]", i),   add_b_v[i],   m_b[i]);
            check_val($sformatf("add_cin[%0d]", i), add_cin_v[i], m_cin[i]);
        end
        // Scoreboard: every done pulse of instance 0 retires one expected result.
        if (done0_v[0] || done1_v[0]) begin
            check_val("sb_depth", exp_q.size(), 1);
            if (exp_q.size() > 0) check_val("sb_result", result_v[0], exp_q.pop_front());
        end
    endtask

    task automatic check_all_zero(input string tag);
        for (int i = 0; i < N_INST; i++) begin
            check_val($sformatf("%s_ctl[%0d]", tag, i),
                      {gnt0_v[i], gnt1_v[i], done0_v[i], done1_v[i], busy_v[i]}, 0);
            check_val($sformatf("%s_result[%0d]", tag, i), result_v[i], 0);
            check_val($sformatf("%s_add[%0d]", tag, i), {add_a_v[i], add_b_v[i], add_cin_v[i]}, 0);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic drive_idle();
        req0 = 1'b0; req1 = 1'b0;
        a0 = 4'd0; b0 = 4'd0; cin0 = 1'b0;
        a1 = 4'd0; b1 = 4'd0; cin1 = 1'b0;
    endtask

    task automatic drive_random();
        req0 = ($urandom_range(0, 2) != 0);
        req1 = ($urandom_range(0, 2) != 0);
        a0 = 4'($urandom_range(0, 15)); b0 = 4'($urandom_range(0, 15)); cin0 = 1'($urandom_range(0, 1));
        a1 = 4'($urandom_range(0, 15)); b1 = 4'($urandom_range(0, 15)); cin1 = 1'($urandom_range(0, 1));
    endtask

    // ---------------- stimulus ----------------
    int rst_hold;

    initial begin
        k = 0;
        model_reset();
        drive_idle();
        rst_n = 1'b0;
        #3;
        check_all_zero("por");

        // Single request from requester 0: 1 + 3 + 0 = 4.
        @(negedge clk);
        rst_n = 1'b1;
        req0 = 1'b1; a0 = 4'b0001; b0 = 4'b0011; cin0 = 1'b0;
        step();
        req0 = 1'b0;
        repeat (5) step();
        check_val("single_result", result_v[0], 5'b00100);

        // Both requesting straight out of reset: 0 first, then 1, alternating.
        rst_n = 1'b0;
        req0 = 1'b1; a0 = 4'b1111; b0 = 4'b0001; cin0 = 1'b0;
        req1 = 1'b1; a1 = 4'b1010; b1 = 4'b0101; cin1 = 1'b1;
        step();
        rst_n = 1'b1;
        repeat (16) step();
        check_val("both_result", result_v[0], 5'b10000);
        drive_idle();
        repeat (20) step();

        // Requester 1 alone; its operand changes during SETTLE must not matter.
        req1 = 1'b1; a1 = 4'b0111; b1 = 4'b0111; cin1 = 1'b1;
        step();
        req1 = 1'b0; a1 = 4'b0000;
        repeat (20) step();
        check_val("hold_result", result_v[0], 5'b01111);

        // Reset in the middle of SETTLE: everything clears at once, no done.
        req0 = 1'b1; a0 = 4'b0101; b0 = 4'b0110; cin0 = 1'b1;
        step();
        req0 = 1'b0;
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("abort");
        step();
        rst_n = 1'b1;
        repeat (3) step();

        // Carry-out through the shortest and longest settle times.
        req0 = 1'b1; a0 = 4'b1000; b0 = 4'b1000; cin0 = 1'b0;
        step();
        req0 = 1'b0;
        repeat (18) step();
        check_val("s1_result", result_v[1], 5'b10000);
        check_val("s15_result", result_v[2], 5'b10000);

        // Randomized traffic with occasional resets.
        rst_hold = 0;
        for (int n = 0; n < 1500; n++) begin
            drive_random();
            if (rst_hold > 0) rst_hold--;
            else if ($urandom_range(0, 149) == 0) rst_hold = $urandom_range(1, 2);
            rst_n = (rst_hold == 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/adder_arbiter.md
ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 Parameter SETTLE_CYCLES, default 2, meaning number of clock cycles the adder inputs are held before add_sum is captured; legal range 1..15.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req0 / req1  input  1 each  level request from requester 0 / 1.
REQ-005 a0, b0 / a1, b1  input  4 each  operands of requester 0 / 1; cin0 / cin1  input  1 each  carry-in.
REQ-006 gnt0 / gnt1  output  1 each  one-cycle pulse: request accepted, operands latched.
REQ-007 done0 / done1  output  1 each  one-cycle pulse: result valid for that requester.
REQ-008 result  output  5  captured sum {carry, sum[3:0]}.
REQ-009 busy  output  1  high whenever FSM not in IDLE.
REQ-010 add_a, add_b  output  4 each; add_cin  output  1: registered drive to the shared 4-bit ripple-carry adder.
REQ-011 add_sum  input  5  combinational sum returned by the shared adder.

Function
REQ-012 FSM states IDLE, SETTLE, DONE; the block SHALL serve exactly one operation at a time.
REQ-013 IDLE: at an edge with req0|req1 high, SHALL select a winner, latch its operands into add_a/add_b/add_cin, load settle counter with SETTLE_CYCLES, go to SETTLE.
REQ-014 Arbitration SHALL be round-robin via a 1-bit priority pointer: both requesting -> pointer owner wins; one requesting -> that one wins regardless of pointer.
REQ-015 gnt of the winner SHALL be high for exactly the first SETTLE cycle; both gnt never high together.
REQ-016 SETTLE: counter decrements each cycle; on the edge where counter equals 1, result SHALL capture add_sum and FSM SHALL go to DONE.
REQ-017 DONE: done of the winner high for exactly that one cycle; pointer SHALL move to the other requester; next state IDLE.
REQ-018 Latency: request sampled at edge N -> gnt high in cycle N+1 -> done and valid result in cycle N+1+SETTLE_CYCLES; new request accepted no earlier than edge N+2+SETTLE_CYCLES.
REQ-019 Requests arriving or changing while not IDLE SHALL be ignored until IDLE; operand changes after grant SHALL NOT affect add_a/add_b/add_cin.
REQ-020 add_a/add_b/add_cin and result SHALL hold their values until the next grant / capture respectively.
REQ-021 A requester holding req high continuously SHALL be re-served only per REQ-014 (no starvation: with both requesting, service strictly alternates).
REQ-022 Result width rule: result[4] is adder carry-out; no truncation or sign handling.

Reset
REQ-023 rst_n low SHALL immediately force: state IDLE, pointer = requester 0, counter 0, gnt0/gnt1/done0/done1/busy = 0, result = 5'b00000, add_a = add_b = 4'b0000, add_cin = 0.
REQ-024 Reset asserted mid-operation SHALL abort it with no done pulse; after release, any still-high req is treated as a new request.
REQ-025 First arbitration after reset release SHALL occur on the first rising edge with rst_n high.

Verification
REQ-026 Reset, then req0=1, a0=0001, b0=0011, cin0=0, SETTLE_CYCLES=2 -> gnt0 one cycle after sampling edge, done0 two cycles later, result=00100.
REQ-027 req0 and req1 high together from reset, a0=1111,b0=0001,cin0=0; a1=1010,b1=0101,cin1=1 -> requester 0 first (result=10000), then requester 1 (result=10000), gnt0/gnt1 alternate while both held.
REQ-028 req1 alone with a1=0111,b1=0111,cin1=1, change a1 to 0000 during SETTLE -> result=01111, busy high for SETTLE_CYCLES+1 cycles.
REQ-029 Assert rst_n low during SETTLE -> all outputs zero asynchronously, no done pulse, busy=0.
REQ-030 SETTLE_CYCLES=1 and =15 with a0=1000,b0=1000,cin0=0 -> result=10000 exactly 1 / 15 cycles after gnt0.
